// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame strobe sequencer (IDLE->COLLIDE x4->KIN x8->XFORM) triggered at beam (0,480); ports clk/rst, vga_x/vga_y, pause, impact in; update_collision/rotate_collision/mirror_collision/update_kinematics/update_transform/handle_impact/update_resonator/busy out; FRAME_SEQ_RESONATOR_EN adds a 32-clock resonator strobe
module frame_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] vga_x,
  input  logic [9:0] vga_y,
  input  logic       pause,
  input  logic [1:0] impact,
  output logic       update_collision,
  output logic       rotate_collision,
  output logic       mirror_collision,
  output logic       update_kinematics,
  output logic       update_transform,
  output logic       handle_impact,
  output logic       update_resonator,
  output logic       busy
);
  localparam logic [1:0] IDLE = 2'd0, COLLIDE = 2'd1, KIN = 2'd2, XFORM = 2'd3;
  logic [1:0] state;
  logic [2:0] step;
  logic       impact_seen;
  logic       trig;
  assign trig = (vga_x == 10'd0) && (vga_y == 10'd480);
  always_ff @(posedge clk)
    if (rst) begin
      state       <= IDLE;
      step        <= 3'd0;
      impact_seen <= 1'b0;
    end else
      case (state)
        IDLE: if (trig) begin
          state       <= pause ? XFORM : COLLIDE;
          step        <= 3'd0;
          impact_seen <= 1'b0;
        end
        COLLIDE: begin
          if (impact != 2'd0) impact_seen <= 1'b1;
          state <= (step == 3'd3) ? KIN : COLLIDE;
          step  <= (step == 3'd3) ? 3'd0 : step + 3'd1;
        end
        KIN: begin
          state <= (step == 3'd7) ? XFORM : KIN;
          step  <= (step == 3'd7) ? 3'd0 : step + 3'd1;
        end
        default: begin
          state <= IDLE;
          step  <= 3'd0;
        end
      endcase
  assign update_collision  = state == COLLIDE;
  assign rotate_collision  = (state == COLLIDE) && step[0];
  assign mirror_collision  = (state == COLLIDE) && step[1];
  assign update_kinematics = state == KIN;
  assign update_transform  = state == XFORM;
  assign handle_impact     = (state == XFORM) && impact_seen;
  assign busy              = state != IDLE;
`ifdef FRAME_SEQ_RESONATOR_EN
  logic [4:0] div;
  always_ff @(posedge clk)
    if (rst) div <= 5'd0;
    else div <= div + 5'd1;
  assign update_resonator = &div;
`else
  assign update_resonator = 1'b0;
`endif
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed table-driven bench for frame_sequencer
module tb_frame_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] vga_x = 10'd5;
  logic [9:0] vga_y = 10'd0;
  logic       pause = 1'b0;
  logic [1:0] impact = 2'd0;
  logic       update_collision, rotate_collision, mirror_collision, update_kinematics;
  logic       update_transform, handle_impact, update_resonator, busy;
  logic [6:0] outs;
  int         total = 0;
  int         bad = 0;
  logic [4:0] mdiv = 5'd0;
  bit         div_ok = 1'b0;

  frame_sequencer dut (
    .clk(clk), .rst(rst), .vga_x(vga_x), .vga_y(vga_y), .pause(pause), .impact(impact),
    .update_collision(update_collision), .rotate_collision(rotate_collision),
    .mirror_collision(mirror_collision), .update_kinematics(update_kinematics),
    .update_transform(update_transform), .handle_impact(handle_impact),
    .update_resonator(update_resonator), .busy(busy)
  );

  always #5 clk = ~clk;

  // {update_collision, rotate, mirror, update_kinematics, update_transform, handle_impact, busy}
  assign outs = {update_collision, rotate_collision, mirror_collision, update_kinematics,
                 update_transform, handle_impact, busy};

  localparam logic [6:0] Z = 7'b0000000, C0 = 7'b1000001, C1 = 7'b1100001, C2 = 7'b1010001,
                         C3 = 7'b1110001, K = 7'b0001001, XN = 7'b0000101, XI = 7'b0000111;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       p;
    logic [1:0] imp;
    logic [6:0] exp;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string n, input logic [6:0] a, input logic [6:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%b want=%b", n, a, e);
    end
  endtask

  // one clock; the resonator model runs alongside every cycle once reset was seen
  task automatic tick();
    logic r;
    logic want;
    r = rst;
    @(posedge clk);
    #1;
    mdiv = r ? 5'd0 : mdiv + 5'd1;
    if (r) div_ok = 1'b1;
`ifdef FRAME_SEQ_RESONATOR_EN
    want = (mdiv == 5'd31);
`else
    want = 1'b0;
`endif
    if (div_ok) chk("resonator", {6'd0, update_resonator}, {6'd0, want});
  endtask

  task automatic add(input logic [9:0] x, input logic [9:0] y, input logic p,
                     input logic [1:0] imp, input logic [6:0] e);
    vec_t v;
    v.x = x; v.y = y; v.p = p; v.imp = imp; v.exp = e;
    vt.push_back(v);
  endtask

  task automatic frame(input logic [1:0] imp3, input logic [6:0] xexp);
    add(10'd0, 10'd480, 1'b0, 2'd0, C0);
    add(10'd5, 10'd0, 1'b0, 2'd0, C1);
    add(10'd5, 10'd0, 1'b0, 2'd0, C2);
    add(10'd5, 10'd0, 1'b0, imp3, C3);
    for (int i = 0; i < 8; i++)
      add(i == 2 ? 10'd0 : 10'd5, i == 2 ? 10'd480 : 10'd0, i == 2 || i == 4, 2'd0, K);
    add(10'd5, 10'd0, 1'b0, 2'd0, xexp);
    add(10'd5, 10'd0, 1'b0, 2'd0, Z);
  endtask

  initial begin
    int n_uc, n_uk, n_ut, n_hi;
    int pos[$];
    frame(2'd1, XI);
    frame(2'd0, XN);
    add(10'd0, 10'd480, 1'b1, 2'd3, XN);
    add(10'd5, 10'd0, 1'b0, 2'd3, Z);
    add(10'd1, 10'd480, 1'b0, 2'd0, Z);
    add(10'd0, 10'd479, 1'b0, 2'd0, Z);
    add(10'd0, 10'd481, 1'b0, 2'd0, Z);

    tick();
    tick();
    chk("reset_state", outs, Z);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", outs, Z);

    for (int i = 0; i < vt.size(); i++) begin
      vga_x = vt[i].x; vga_y = vt[i].y; pause = vt[i].p; impact = vt[i].imp;
      tick();
      chk($sformatf("vec%0d", i), outs, vt[i].exp);
    end
    vga_x = 10'd5; vga_y = 10'd0; pause = 1'b0; impact = 2'd0;

    // reset mid-KIN, then a full sequence must follow the next trigger
    vga_x = 10'd0; vga_y = 10'd480;
    tick();
    vga_x = 10'd5; vga_y = 10'd0;
    repeat (5) tick();
    chk("mid_kin", outs, K);
    rst = 1'b1;
    tick();
    chk("reset_mid_seq", outs, Z);
    rst = 1'b0;
    tick();
    chk("idle_post_rst", outs, Z);
    vga_x = 10'd0; vga_y = 10'd480; impact = 2'd2;
    tick();
    vga_x = 10'd5; vga_y = 10'd0;
    n_uc = 0; n_uk = 0; n_ut = 0; n_hi = 0;
    for (int c = 0; c < 13; c++) begin
      n_uc += int'(update_collision);
      n_uk += int'(update_kinematics);
      n_ut += int'(update_transform);
      n_hi += int'(handle_impact);
      if (c == 12) chk("post_rst_xform", outs, XI);
      tick();
    end
    impact = 2'd0;
    chk("post_rst_collide_cnt", 7'(n_uc), 7'd4);
    chk("post_rst_kin_cnt", 7'(n_uk), 7'd8);
    chk("post_rst_xform_cnt", 7'(n_ut), 7'd1);
    chk("post_rst_impact_cnt", 7'(n_hi), 7'd1);
    chk("post_rst_idle", outs, Z);

    // resonator cadence from reset release, with frames running
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      vga_x = (c % 20 == 0) ? 10'd0 : 10'd5;
      vga_y = (c % 20 == 0) ? 10'd480 : 10'd0;
      pause = (c % 40 == 0);
      tick();
      if (update_resonator) pos.push_back(c);
    end
`ifdef FRAME_SEQ_RESONATOR_EN
    chk("res_pulse_cnt", 7'(pos.size()), 7'd3);
    if (pos.size() == 3) begin
      chk("res_pulse0", 7'(pos[0]), 7'd31);
      chk("res_pulse1", 7'(pos[1]), 7'd63);
      chk("res_pulse2", 7'(pos[2]), 7'd95);
    end
`else
    chk("res_pulse_cnt", 7'(pos.size()), 7'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 The block SHALL use one clock and synchronous active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 vga_x input 10: beam column from the VGA beam generator.
REQ-003 vga_y input 10: beam row from the VGA beam generator.
REQ-004 pause input 1: when high at frame trigger, skip the collision and kinematics phases.
REQ-005 impact input 2: collision impact class from the collision unit; nonzero means impact.
REQ-006 update_collision output 1: collision-unit step strobe.
REQ-007 rotate_collision output 1: rotate qualifier for the collision step.
REQ-008 mirror_collision output 1: mirror qualifier for the collision step.
REQ-009 update_kinematics output 1: kinematics step strobe.
REQ-010 update_transform output 1: transform reload strobe.
REQ-011 handle_impact output 1: one-cycle impact notification to colour/orientation logic.
REQ-012 update_resonator output 1: audio resonator sample strobe.
REQ-013 busy output 1: high while the sequence is running.

Function
REQ-014 FSM states SHALL be IDLE, COLLIDE, KIN, XFORM; all outputs except update_resonator SHALL be Moore decodes of state and step counter.
REQ-015 Frame trigger SHALL be vga_x==0 && vga_y==480, sampled at a clk edge while in IDLE.
REQ-016 Trigger in IDLE with pause=0 -> COLLIDE, step=0; with pause=1 -> XFORM directly.
REQ-017 COLLIDE SHALL last 4 cycles (step 0..3): update_collision=1, rotate_collision=step[0], mirror_collision=step[1]; after step 3 -> KIN, step=0.
REQ-018 KIN SHALL last 8 cycles (step 0..7) with update_kinematics=1; after step 7 -> XFORM.
REQ-019 XFORM SHALL last 1 cycle with update_transform=1, then -> IDLE.
REQ-020 Latency: trigger sampled at edge T -> COLLIDE in cycles T+1..T+4, KIN T+5..T+12, XFORM T+13, IDLE from T+14; with pause, XFORM T+1, IDLE T+2.
REQ-021 busy SHALL be 1 in every non-IDLE state.
REQ-022 impact_seen flag SHALL clear on the IDLE->COLLIDE and IDLE->XFORM transitions, and set on any COLLIDE cycle with impact!=0.
REQ-023 handle_impact SHALL equal (state==XFORM) && impact_seen: at most one pulse per frame, never on a paused frame.
REQ-024 Trigger condition while not IDLE SHALL be ignored, with no queueing.
REQ-025 pause changes outside the trigger cycle SHALL NOT alter a running sequence.
REQ-026 Step counter SHALL be 3 bits and reset to 0 on every state change.
REQ-027 update_collision, update_kinematics and update_transform SHALL be mutually exclusive in every cycle.
REQ-028 rotate_collision and mirror_collision SHALL be 0 outside COLLIDE.

Reset
REQ-029 On rst=1 at a clk edge: state=IDLE, step=0, impact_seen=0, resonator divider=0.
REQ-030 All outputs SHALL be 0 in the cycle after rst, including when rst occurs mid-sequence.
REQ-031 The first trigger after reset release SHALL start a full sequence.

Configuration
REQ-032 Macro FRAME_SEQ_RESONATOR_EN defined: a free-running 5-bit divider SHALL be present and update_resonator SHALL pulse for one cycle when the divider equals 31, i.e. every 32 clocks, independent of FSM state and pause.
REQ-033 FRAME_SEQ_RESONATOR_EN undefined: the divider SHALL be absent and update_resonator SHALL be constant 0.

Verification
REQ-034 Reset, then hold vga_x=0, vga_y=480 for one cycle with pause=0 -> cycles T+1..T+4 give {rotate,mirror}=00,10,01,11 with update_collision=1; T+5..T+12 update_kinematics=1; T+13 update_transform=1; busy=0 at T+14.
REQ-035 Same trigger with impact=2'b01 during cycle T+3 only -> handle_impact=1 at T+13 only; repeat the trigger with impact=0 -> handle_impact=0 throughout.
REQ-036 Trigger with pause=1 and impact=2'b11 held -> update_transform=1 at T+1, no collision/kinematics strobes, handle_impact=0, busy=0 at T+2.
REQ-037 Assert rst at T+6 (mid-KIN) -> all outputs 0 at T+7; next trigger -> full 13-cycle sequence.
REQ-038 With FRAME_SEQ_RESONATOR_EN defined, release reset at cycle 0 -> update_resonator pulses at cycles 31, 63, 95 regardless of sequence activity; macro undefined -> update_resonator never 1.
